// File: rtl/bf_sequencer.sv
// Brainfuck control sequencer: fetches opcodes, drives the cell ALU select triple,
// handles pointer moves, byte I/O and loops. Optional BF_INSN_COUNT_EN adds insn_count.
module bf_sequencer #(
  parameter int PC_W        = 10,
  parameter int DP_W        = 8,
  parameter int STACK_DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [PC_W-1:0] pc,
  input  logic [7:0]      instr,
  output logic [DP_W-1:0] dp,
  input  logic [7:0]      dmem_rdata,
  output logic            dmem_we,
  output logic [7:0]      dmem_wdata,
  output logic [7:0]      alu_a,
  output logic            nochange,
  output logic            decrement,
  output logic            increment,
  input  logic [7:0]      alu_out,
  output logic            out_valid,
  output logic [7:0]      out_data,
  input  logic            out_ready,
  input  logic            in_valid,
  input  logic [7:0]      in_data,
  output logic            in_ready,
  output logic            halted,
`ifdef BF_INSN_COUNT_EN
  output logic [31:0]     insn_count,
`endif
  output logic            error
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = $clog2(STACK_DEPTH);

  typedef enum logic [2:0] {IDLE, RUN, SCAN, HALT, ERROR} state_t;

  state_t          state;
  logic [SP_W-1:0] sp;
  logic [PC_W:0]   depth;
  logic [PC_W-1:0] stack [STACK_DEPTH];

  logic run, op_inc, op_dec, op_out, op_in, op_open, op_close;
  logic cell_zero, stack_full, stack_empty, do_push;
  logic [PC_W-1:0] pc_inc;
  logic [IDX_W-1:0] push_idx, top_idx;

  assign run      = (state == RUN);
  assign op_inc   = run && (instr == 8'h2B);
  assign op_dec   = run && (instr == 8'h2D);
  assign op_out   = run && (instr == 8'h2E);
  assign op_in    = run && (instr == 8'h2C);
  assign op_open  = run && (instr == 8'h5B);
  assign op_close = run && (instr == 8'h5D);

  assign cell_zero   = (dmem_rdata == 8'h00);
  assign stack_full  = (sp == SP_W'(STACK_DEPTH));
  assign stack_empty = (sp == '0);
  assign pc_inc      = pc + PC_W'(1);
  assign push_idx    = IDX_W'(sp);
  assign top_idx     = IDX_W'(sp - SP_W'(1));
  assign do_push     = op_open && !cell_zero && !stack_full;

  // Everything below is decoded straight from state and instr so handshakes drop with reset.
  assign increment  = op_inc;
  assign decrement  = op_dec;
  assign nochange   = !(op_inc || op_dec);
  assign dmem_we    = op_inc || op_dec || (op_in && in_valid);
  assign dmem_wdata = alu_out;
  assign alu_a      = op_in ? in_data : dmem_rdata;
  assign out_valid  = op_out;
  assign out_data   = dmem_rdata;
  assign in_ready   = op_in;

  // NOTE: the return stack is a plain memory with no reset; sp alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) stack[push_idx] <= pc;
  end

  // NOTE: all sequential state uses non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      pc     <= '0;
      dp     <= '0;
      sp     <= '0;
      depth  <= '0;
      halted <= 1'b0;
      error  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= RUN;
          pc    <= '0;
        end
        RUN: case (instr)
          8'h3E: begin dp <= dp + DP_W'(1); pc <= pc_inc; end
          8'h3C: begin dp <= dp - DP_W'(1); pc <= pc_inc; end
          8'h2E: if (out_ready) pc <= pc_inc;
          8'h2C: if (in_valid) pc <= pc_inc;
          8'h5B: begin
            if (cell_zero) begin
              depth <= (PC_W+1)'(1);
              pc    <= pc_inc;
              state <= SCAN;
            end else if (stack_full) begin
              state <= ERROR;
              error <= 1'b1;
            end else begin
              sp <= sp + SP_W'(1);
              pc <= pc_inc;
            end
          end
          8'h5D: begin
            if (stack_empty) begin
              state <= ERROR;
              error <= 1'b1;
            end else if (!cell_zero) begin
              pc <= stack[top_idx] + PC_W'(1);
            end else begin
              sp <= sp - SP_W'(1);
              pc <= pc_inc;
            end
          end
          8'h00: begin
            state  <= HALT;
            halted <= 1'b1;
          end
          default: pc <= pc_inc;
        endcase
        SCAN: case (instr)
          8'h5B: begin depth <= depth + (PC_W+1)'(1); pc <= pc_inc; end
          8'h5D: begin
            if (depth == (PC_W+1)'(1)) state <= RUN;
            else depth <= depth - (PC_W+1)'(1);
            pc <= pc_inc;
          end
          8'h00: begin
            state <= ERROR;
            error <= 1'b1;
          end
          default: pc <= pc_inc;
        endcase
        default: ;  // HALT and ERROR are sticky until reset
      endcase
    end
  end

`ifdef BF_INSN_COUNT_EN
  logic retire;
  // A RUN opcode retires whenever pc moves; stalls, faults and the halt opcode do not.
  assign retire = run && (op_out   ? out_ready :
                          op_in    ? in_valid :
                          op_open  ? (cell_zero || !stack_full) :
                          op_close ? !stack_empty :
                          (instr != 8'h00));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) insn_count <= '0;
    else if (retire && (insn_count != 32'hFFFF_FFFF)) insn_count <= insn_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_bf_sequencer.sv
// Directed bench for bf_sequencer: bench-side ROM, RAM and ALU, hand-computed expectations.
module tb_bf_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, start;
  logic [9:0] pc;
  logic [7:0] instr;
  logic [7:0] dp;
  logic [7:0] dmem_rdata, dmem_wdata, alu_a, alu_out;
  logic       dmem_we, nochange, decrement, increment;
  logic       out_valid, out_ready, in_valid, in_ready, halted, error;
  logic [7:0] out_data, in_data;
`ifdef BF_INSN_COUNT_EN
  logic [31:0] insn_count;
`endif

  logic [7:0] rom [1024];
  logic [7:0] ram [256];
  logic [7:0] preset0;

  int checks   = 0;
  int failures = 0;
  int n, inc_cnt, dec_cnt;

  always #5 clk = ~clk;

  bf_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pc(pc), .instr(instr), .dp(dp),
    .dmem_rdata(dmem_rdata), .dmem_we(dmem_we), .dmem_wdata(dmem_wdata), .alu_a(alu_a),
    .nochange(nochange), .decrement(decrement), .increment(increment), .alu_out(alu_out),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .halted(halted),
`ifdef BF_INSN_COUNT_EN
    .insn_count(insn_count),
`endif
    .error(error)
  );

  // Environment: combinational ROM/RAM reads and a simple cell ALU.
  assign instr      = rom[pc];
  assign dmem_rdata = ram[dp];
  assign alu_out    = increment ? alu_a + 8'd1 : (decrement ? alu_a - 8'd1 : alu_a);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
      ram[0] <= preset0;
    end else if (dmem_we) begin
      ram[dp] <= dmem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input string s);
    for (int i = 0; i < 1024; i++) rom[i] = 8'h00;
    for (int i = 0; i < s.len(); i++) rom[i] = s[i];
  endtask

  task automatic do_reset(input logic [7:0] cell0);
    @(negedge clk);
    preset0 = cell0; rst_n = 1'b0; start = 1'b0;
    out_ready = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic kick();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // which: 0 = halted/error, 1 = out_valid, 2 = in_ready. Counts select strobes on the way.
  task automatic wait_for(input int which, input string tag);
    n = 0; inc_cnt = 0; dec_cnt = 0;
    while (n < 300 && !((which == 0 && (halted || error)) ||
                        (which == 1 && out_valid) || (which == 2 && in_ready))) begin
      inc_cnt += int'(increment);
      dec_cnt += int'(decrement);
      @(negedge clk);
      n++;
    end
    if (n >= 300) check({tag, "_timeout"}, 32'(n), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    preset0 = 8'h00;
    load("+++-");
    #12;
    // Reset state
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_dp", 32'(dp), 32'd0);
    check("rst_sel", {29'd0, nochange, decrement, increment}, 32'b100);
    check("rst_hs", {29'd0, dmem_we, out_valid, in_ready}, 32'd0);
    check("rst_flags", {30'd0, halted, error}, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // "+++-" then halt
    kick();
    wait_for(0, "t1");
    check("t1_cycles", 32'(n), 32'd5);
    check("t1_cell0", 32'(ram[0]), 32'h02);
    check("t1_inc", 32'(inc_cnt), 32'd3);
    check("t1_dec", 32'(dec_cnt), 32'd1);
    check("t1_flags", {30'd0, halted, error}, 32'b10);
    check("t1_pc", 32'(pc), 32'd4);
    kick();
    check("t1_sticky", {22'd0, pc, halted}, {22'd0, 10'd4, 1'b1});

    // Decrement wrap
    load("-");
    do_reset(8'h00);
    kick();
    wait_for(0, "t2");
    check("t2_cell0", 32'(ram[0]), 32'hFF);

    // Pointer wrap
    load("<");
    do_reset(8'h00);
    kick();
    wait_for(0, "t3");
    check("t3_dp", 32'(dp), 32'hFF);

    // Move loop then output with backpressure
    load("++[->+<]>.");
    do_reset(8'h00);
    kick();
    wait_for(1, "t4");
    check("t4_pc", 32'(pc), 32'd9);
    check("t4_dp", 32'(dp), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_hold", {22'd0, pc, out_valid}, {22'd0, 10'd9, 1'b1});
    end
    out_ready = 1'b1;
    #1;
    check("t4_xfer", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h02});
    @(negedge clk);
    check("t4_adv", 32'(pc), 32'd10);
    wait_for(0, "t4b");
    check("t4_cells", {16'd0, ram[1], ram[0]}, 32'h0200);
    check("t4_halt", {30'd0, halted, error}, 32'b10);

    // Nested skip
    load("[[+]].");
    do_reset(8'h00);
    out_ready = 1'b1;
    kick();
    wait_for(1, "t5");
    check("t5_pc", 32'(pc), 32'd5);
    check("t5_out", 32'(out_data), 32'h00);
    wait_for(0, "t5b");
    check("t5_end", {22'd0, ram[0], halted, error}, 32'b10);

    // Unmatched ']'
    load("]");
    do_reset(8'h00);
    kick();
    wait_for(0, "t6");
    check("t6_cycles", 32'(n), 32'd1);
    check("t6_flags", {30'd0, halted, error}, 32'b01);

    // Stack overflow on the 17th '['
    load("[[[[[[[[[[[[[[[[[");
    do_reset(8'h01);
    kick();
    wait_for(0, "t7");
    check("t7_flags", {30'd0, halted, error}, 32'b01);
    check("t7_pc", 32'(pc), 32'd16);
    kick();
    check("t7_sticky", {30'd0, halted, error}, 32'b01);

    // Unmatched '[' found during scan
    load("[");
    do_reset(8'h00);
    kick();
    wait_for(0, "t8");
    check("t8_flags", {30'd0, halted, error}, 32'b01);

    // Input then echo
    load(",.");
    do_reset(8'h00);
    kick();
    wait_for(2, "t9");
    repeat (2) @(negedge clk);
    check("t9_stall", {22'd0, pc, in_ready}, {22'd0, 10'd0, 1'b1});
    in_data = 8'h41; in_valid = 1'b1;
    #1;
    check("t9_in", {23'd0, dmem_we, alu_a}, {23'd0, 1'b1, 8'h41});
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    check("t9_out", {22'd0, pc, out_data}, {22'd0, 10'd1, 8'h41});
    wait_for(0, "t9b");
    check("t9_cell0", 32'(ram[0]), 32'h41);
`ifdef BF_INSN_COUNT_EN
    check("t9_count", insn_count, 32'd2);
`endif

    // Reset mid-handshake
    load(".");
    do_reset(8'h00);
    kick();
    wait_for(1, "t10");
    rst_n = 1'b0;
    #1;
    check("t10_drop", {29'd0, out_valid, in_ready, dmem_we}, 32'd0);
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bf_sequencer.md
Name: bf_sequencer

Overview:
- Brainfuck control sequencer: fetches one opcode per cycle from program ROM and drives the cell ALU control triple (nochange/decrement/increment).
- Writes the ALU result back to data memory, moves the data pointer, runs byte I/O handshakes, and resolves loops with a return stack plus forward bracket scan.
- Sits between program ROM, data RAM, the alu block and the I/O ports; it is the command-issuing end of the ALU control interface.

Parameters:
- PC_W, 10, program counter width; program space is 2^PC_W bytes.
- DP_W, 8, data pointer width; tape is 2^DP_W cells.
- STACK_DEPTH, 16, loop return stack entries.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins execution from IDLE
- pc  out  PC_W  program address
- instr  in  8  ROM byte at pc; combinational, same cycle
- dp  out  DP_W  data address
- dmem_rdata  in  8  cell at dp; combinational, same cycle
- dmem_we  out  1  write strobe; dmem_wdata is captured at the clock edge
- dmem_wdata  out  8  equals alu_out
- alu_a  out  8  ALU operand: in_data during ',' else dmem_rdata
- nochange  out  1  ALU pass-through select
- decrement  out  1  ALU a-1 select
- increment  out  1  ALU a+1 select
- alu_out  in  8  ALU result
- out_valid  out  1  output byte valid
- out_data  out  8  output byte (dmem_rdata)
- out_ready  in  1  consumer ready
- in_valid  in  1  input byte valid
- in_data  in  8  input byte
- in_ready  out  1  sequencer ready for input
- halted  out  1  sticky; 0x00 opcode executed
- error  out  1  sticky; stack overflow/underflow or unmatched '['

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; pc=0; dp=0; stack pointer=0; scan depth=0.
  - halted=0, error=0.
  - Combinational outputs: dmem_we=0, out_valid=0, in_ready=0, nochange=1, increment=0, decrement=0.
- Select encoding: {nochange, decrement, increment} is always one-hot. nochange=1 in every state and opcode except '+' (increment) and '-' (decrement).
- States: IDLE, RUN, SCAN, HALT, ERROR. All outputs other than pc, dp, halted and error are combinational from state and instr.
- IDLE: on start, go to RUN next cycle with pc=0. Any other input is ignored.
- RUN, one opcode per cycle. pc advances by 1 (wrapping mod 2^PC_W) unless stated otherwise.
  - 0x2B '+': increment=1, dmem_we=1.
  - 0x2D '-': decrement=1, dmem_we=1.
  - 0x3E '>': dp+1. 0x3C '<': dp-1. Both wrap mod 2^DP_W.
  - 0x2E '.': out_valid=1. pc holds until out_valid&&out_ready; advances in the transfer cycle.
  - 0x2C ',': in_ready=1, alu_a=in_data, nochange=1, dmem_we=in_valid. pc advances when in_valid.
  - 0x5B '[', cell!=0: push pc. If stack already holds STACK_DEPTH entries, go to ERROR instead (pc unchanged, no push).
  - 0x5B '[', cell==0: depth=1, pc+1, go to SCAN.
  - 0x5D ']', stack empty: go to ERROR.
  - 0x5D ']', cell!=0: pc=top+1, stack unchanged.
  - 0x5D ']', cell==0: pop, pc+1.
  - 0x00: go to HALT; pc holds.
  - Any other byte: no-op, pc+1.
- SCAN, one byte per cycle, pc+1 each cycle:
  - '[' : depth+1.
  - ']' with depth>1: depth-1.
  - ']' with depth==1: pc+1, go to RUN.
  - 0x00: go to ERROR.
  - depth counter width PC_W+1; never overflows.
- HALT: halted=1. ERROR: error=1. Both are sticky until reset; start is ignored.
- Reset mid-handshake: out_valid/in_ready drop in the same instant; no write occurs.

Optional Feature:
- Macro BF_INSN_COUNT_EN.
- Defined: adds output insn_count (32 bits), reset 0. Increments once per retired RUN opcode, i.e. each cycle pc advances or jumps in RUN (the halt opcode excluded). Stall cycles and SCAN cycles do not count. Saturates at 0xFFFFFFFF.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- ROM "+++-" then 0x00, cell0=0, start -> cell0=0x02 after 4 RUN cycles; halted=1 on the 5th; increment high exactly 3 cycles, decrement 1.
- ROM "-" then 0x00 with cell0=0x00 -> cell0=0xFF (wrap). ROM "<" then 0x00 -> dp=0xFF.
- ROM "++[->+<]>." then 0x00 -> cell1=0x02; out_valid held while out_ready=0 for 3 cycles; out_data=0x02 transfers on the first out_ready=1 cycle.
- ROM "[[+]]." then 0x00 with cell0=0 -> SCAN skips both nested loops, cell0 stays 0; out_data=0x00.
- ROM "]" -> error=1 next cycle. 17 nested '[' with cell0=1, STACK_DEPTH=16 -> error=1 on the 17th '['. ROM "[" then 0x00 with cell=0 -> error=1.
- ROM ",." with in_valid asserted after 2 idle cycles, in_data=0x41 -> cell0=0x41, out_data=0x41. With BF_INSN_COUNT_EN -> insn_count=2 at halt.
